// File: rtl/vred_stream_unit_pkg.sv
// Shared vALU reduction definitions: op codes, SEW encodings, FSM state type,
// and the helpers used by the beat fold tree and the accumulator step.
//   vred_sew_bits  : element width in bits for a sew code
//   vred_sew_mask  : all-ones mask of the element width
//   vred_identity  : value that leaves a reduction unchanged (masked-off lanes)
//   vred_combine   : two-operand reduction step at the given op/sew
package vred_stream_unit_pkg;

  localparam logic [2:0] RED_SUM  = 3'd0;
  localparam logic [2:0] RED_MINU = 3'd1;
  localparam logic [2:0] RED_MIN  = 3'd2;
  localparam logic [2:0] RED_MAXU = 3'd3;
  localparam logic [2:0] RED_MAX  = 3'd4;
  localparam logic [2:0] RED_AND  = 3'd5;
  localparam logic [2:0] RED_OR   = 3'd6;
  localparam logic [2:0] RED_XOR  = 3'd7;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} vred_state_e;

  function automatic int unsigned vred_sew_bits(input logic [1:0] sew);
    return 32'd8 << sew;
  endfunction

  function automatic logic [63:0] vred_sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Sign-extend the low SEW bits so signed compares work at any element width.
  function automatic logic signed [63:0] vred_sext(input logic [63:0] v, input logic [1:0] sew);
    case (sew)
      SEW_8:   return {{56{v[7]}}, v[7:0]};
      SEW_16:  return {{48{v[15]}}, v[15:0]};
      SEW_32:  return {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [63:0] vred_identity(input logic [2:0] op, input logic [1:0] sew);
    logic [63:0] m;
    m = vred_sew_mask(sew);
    case (op)
      RED_AND, RED_MINU: return m;
      RED_MIN:           return m >> 1;           // signed max: 0111..1
      RED_MAX:           return m & ~(m >> 1);    // signed min: 1000..0
      default:           return 64'd0;            // SUM, OR, XOR, MAXU
    endcase
  endfunction

  function automatic logic [63:0] vred_combine(input logic [2:0] op, input logic [1:0] sew,
                                               input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, am, bm;
    logic        slt;
    m   = vred_sew_mask(sew);
    am  = a & m;
    bm  = b & m;
    slt = vred_sext(am, sew) < vred_sext(bm, sew);
    case (op)
      RED_SUM:  return (am + bm) & m;
      RED_MINU: return (am < bm) ? am : bm;
      RED_MIN:  return slt ? am : bm;
      RED_MAXU: return (am < bm) ? bm : am;
      RED_MAX:  return slt ? bm : am;
      RED_AND:  return am & bm;
      RED_OR:   return am | bm;
      default:  return am ^ bm;
    endcase
  endfunction

endpackage

// File: rtl/vred_stream_unit_fold.sv
// Combinational fold of one beat into a single SEW-wide element.
// Masked-off (or out-of-range) lanes become the op identity, then a
// log2 tree of vred_combine reduces them.
//   data   : packed elements of the beat
//   mask   : per-byte mask; an element is active iff its lowest byte bit is set
//   op/sew : reduction op and element width
//   result : folded element in the low SEW bits, upper bits zero
module vred_lane_fold
  import vred_stream_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] mask,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [SEW_WIDTH-1:0]    sew,
  output logic [63:0]             result
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LOG = $clog2(NB);

  // Leaves are sized for the narrowest SEW; wider SEWs fill only the low slots.
  function automatic logic [63:0] leaf_value(input int unsigned idx,
                                             input logic [DATA_WIDTH-1:0] d,
                                             input logic [NB-1:0] m,
                                             input logic [OP_WIDTH-1:0] o,
                                             input logic [SEW_WIDTH-1:0] s);
    int unsigned     ebits;
    int unsigned     ebytes;
    logic [NB-1:0]   msh;
    ebits  = vred_sew_bits(s);
    ebytes = ebits / 8;
    if (idx * ebytes >= NB) return vred_identity(o, s);
    msh = m >> (idx * ebytes);
    if (!msh[0]) return vred_identity(o, s);
    return 64'(d >> (idx * ebits)) & vred_sew_mask(s);
  endfunction

  for (genvar l = 0; l <= LOG; l++) begin : g_lvl
    localparam int unsigned N = NB >> l;
    logic [63:0] node [N];
    for (genvar i = 0; i < N; i++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node[i] = leaf_value(i, data, mask, op, sew);
      end else begin : g_pair
        assign node[i] = vred_combine(op, sew, g_lvl[l-1].node[2*i], g_lvl[l-1].node[2*i+1]);
      end
    end
  end

  assign result = g_lvl[LOG].node[0];

endmodule

// File: rtl/vred_stream_unit.sv
// Multi-beat vector reduction engine. Folds a stream of operand beats into
// one SEW-wide scalar seeded by in_scalar.
//   in_*        : beat stream (valid/ready), first/last framing, op/sew/scalar
//                 sampled on first beats only
//   out_*       : result (valid/ready), held in DONE until consumed
//   out_restart : one-cycle pulse when a new reduction pre-empts an open one
module vred_stream_unit
  import vred_stream_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [63:0]             in_scalar,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [SEW_WIDTH-1:0]    sew,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_restart
);

  vred_state_e          state_q, state_d;
  logic [63:0]          acc_q, acc_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [SEW_WIDTH-1:0] sew_q, sew_d;
  logic                 restart_q, restart_d;

  logic                 accept;
  logic [OP_WIDTH-1:0]  fold_op;
  logic [SEW_WIDTH-1:0] fold_sew;
  logic [63:0]          fold_res;

  // A first beat folds with its own op/sew, not the latched ones.
  assign fold_op  = in_first ? op  : op_q;
  assign fold_sew = in_first ? sew : sew_q;

  vred_lane_fold #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEW_WIDTH (SEW_WIDTH),
    .OP_WIDTH  (OP_WIDTH)
  ) u_fold (
    .data  (in_data),
    .mask  (in_mask),
    .op    (fold_op),
    .sew   (fold_sew),
    .result(fold_res)
  );

  assign in_ready = (state_q != StDone);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    sew_d     = sew_q;
    restart_d = 1'b0;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept && in_first) begin
          op_d      = op;
          sew_d     = sew;
          acc_d     = vred_combine(op, sew, in_scalar, fold_res);
          state_d   = in_last ? StDone : StAccum;
          restart_d = (state_q == StAccum);
        end else if (accept && (state_q == StAccum)) begin
          acc_d = vred_combine(op_q, sew_q, acc_q, fold_res);
          if (in_last) state_d = StDone;
        end
        // Non-first beats in IDLE are dropped.
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      sew_q     <= sew_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == StDone) out_data[63:0] = acc_q;
  end

  assign out_valid   = (state_q == StDone);
  assign out_restart = restart_q;

endmodule
